// File: rtl/fp_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_pkg
// Description : Shared widths, unpacked-operand type and field helpers for
//               the single-precision FP adder/subtractor pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_add_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = 24;
  localparam int GRS_W   = 3;
  localparam int ALIGN_W = MANT_W + GRS_W;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_unpacked_t;

  // Split a raw binary32 word; the hidden bit is present for any nonzero exponent.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] raw);
    fp_unpacked_t u;
    u.sign = raw[31];
    u.exp  = raw[30:FRAC_W];
    u.mant = {(raw[30:FRAC_W] != '0), raw[FRAC_W-1:0]};
    return u;
  endfunction

  // Denormals and zero share the scale of exponent 1.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  function automatic logic is_special(input logic [EXP_W-1:0] e);
    return (e == EXP_SPECIAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_align_shifter.sv
`default_nettype none
// ============================================================================
// Module      : fp_align_shifter
// Description : Combinational right shifter for mantissa alignment. Bits
//               shifted out are collapsed into a sticky bit ORed into bit 0.
// Ports       : i_val    [26:0] value to shift ({mantissa, guard, round, sticky})
//               i_shamt  [7:0]  right-shift amount
//               o_val    [26:0] shifted value with sticky in bit 0
// Revision    : 1.0 - initial release
// ============================================================================
module fp_align_shifter
  import fp_add_pkg::*;
(
  input  logic [ALIGN_W-1:0] i_val,
  input  logic [EXP_W-1:0]   i_shamt,
  output logic [ALIGN_W-1:0] o_val
);

  logic              w_big;
  logic [ALIGN_W-1:0] w_mask;
  logic [ALIGN_W-1:0] w_shifted;
  logic               w_sticky;

  assign w_big = (i_shamt >= EXP_W'(ALIGN_W));

  // Low i_shamt bits set: exactly the bits that fall off the right end.
  assign w_mask    = ~({ALIGN_W{1'b1}} << i_shamt[4:0]);
  assign w_shifted = w_big ? '0 : (i_val >> i_shamt[4:0]);
  assign w_sticky  = w_big ? (|i_val) : (|(i_val & w_mask));

  assign o_val = {w_shifted[ALIGN_W-1:1], w_shifted[0] | w_sticky};

endmodule
`default_nettype wire

// File: rtl/fp_add_align.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_align
// Description : Operand unpack and alignment stage of the binary32 adder.
//               Orders operands by magnitude, computes the effective
//               exponent difference and right-aligns the smaller mantissa
//               with guard/round/sticky. Two-stage valid/ready pipeline.
// Ports       : clk, rst (async, active-high)
//               i_in_valid / o_in_ready       upstream handshake
//               i_a, i_b [31:0], i_op_sub      raw operands and opcode
//               o_out_valid / i_out_ready     downstream handshake
//               o_exp_x/y, o_mantissa_x/y, o_sign_x/y   ordered fields
//               o_swap, o_do_subtract, o_exp_diff, o_aligned_y
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_align
  import fp_add_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [31:0]        i_a,
  input  logic [31:0]        i_b,
  input  logic               i_op_sub,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [EXP_W-1:0]   o_exp_x,
  output logic [EXP_W-1:0]   o_exp_y,
  output logic [MANT_W-1:0]  o_mantissa_x,
  output logic [MANT_W-1:0]  o_mantissa_y,
  output logic               o_sign_x,
  output logic               o_sign_y,
  output logic               o_swap,
  output logic               o_do_subtract,
  output logic [EXP_W-1:0]   o_exp_diff,
  output logic [ALIGN_W-1:0] o_aligned_y
);

  // ---------------- handshake ----------------
  logic r_s1_valid, r_s2_valid;
  logic w_s2_load, w_in_ready, w_s1_load;

  assign w_s2_load  = !r_s2_valid || i_out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_s1_load  = i_in_valid && w_in_ready;

  // ---------------- stage 1: unpack and order ----------------
  logic         w_swap;
  fp_unpacked_t w_x, w_y;
  logic [EXP_W-1:0] w_exp_diff;
  logic         w_do_sub;

  // Sign-free compare of {exp, frac}; ties keep a as the larger operand.
  assign w_swap     = (i_b[30:0] > i_a[30:0]);
  assign w_x        = fp_unpack(w_swap ? i_b : i_a);
  assign w_y        = fp_unpack(w_swap ? i_a : i_b);
  assign w_exp_diff = eff_exp(w_x.exp) - eff_exp(w_y.exp);
  assign w_do_sub   = i_op_sub ^ i_a[31] ^ i_b[31];

  fp_unpacked_t     r_s1_x, r_s1_y;
  logic             r_s1_swap, r_s1_do_sub;
  logic [EXP_W-1:0] r_s1_diff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_swap   <= 1'b0;
      r_s1_do_sub <= 1'b0;
      r_s1_diff   <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid  <= 1'b1;
        r_s1_x      <= w_x;
        r_s1_y      <= w_y;
        r_s1_swap   <= w_swap;
        r_s1_do_sub <= w_do_sub;
        r_s1_diff   <= w_exp_diff;
      end else if (w_s2_load) begin
        // Stage 1 contents moved into stage 2 and nothing replaced them.
        r_s1_valid <= 1'b0;
      end
    end
  end

  // ---------------- stage 2: align ----------------
  logic [ALIGN_W-1:0] w_aligned;

  fp_align_shifter u_shifter (
    .i_val   ({r_s1_y.mant, {GRS_W{1'b0}}}),
    .i_shamt (r_s1_diff),
    .o_val   (w_aligned)
  );

  fp_unpacked_t       r_s2_x, r_s2_y;
  logic               r_s2_swap, r_s2_do_sub;
  logic [EXP_W-1:0]   r_s2_diff;
  logic [ALIGN_W-1:0] r_s2_aligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_x       <= '0;
      r_s2_y       <= '0;
      r_s2_swap    <= 1'b0;
      r_s2_do_sub  <= 1'b0;
      r_s2_diff    <= '0;
      r_s2_aligned <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      // Data only moves with a real item, so idle outputs keep the last result.
      if (r_s1_valid) begin
        r_s2_x       <= r_s1_x;
        r_s2_y       <= r_s1_y;
        r_s2_swap    <= r_s1_swap;
        r_s2_do_sub  <= r_s1_do_sub;
        r_s2_diff    <= r_s1_diff;
        r_s2_aligned <= w_aligned;
      end
    end
  end

  // ---------------- outputs ----------------
  assign o_in_ready    = w_in_ready;
  assign o_out_valid   = r_s2_valid;
  assign o_exp_x       = r_s2_x.exp;
  assign o_exp_y       = r_s2_y.exp;
  assign o_mantissa_x  = r_s2_x.mant;
  assign o_mantissa_y  = r_s2_y.mant;
  assign o_sign_x      = r_s2_x.sign;
  assign o_sign_y      = r_s2_y.sign;
  assign o_swap        = r_s2_swap;
  assign o_do_subtract = r_s2_do_sub;
  assign o_exp_diff    = r_s2_diff;
  assign o_aligned_y   = r_s2_aligned;

endmodule
`default_nettype wire

// File: tb/tb_fp_add_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_align
// Description : Self-checking bench for fp_add_align. Stimulus pushes the
//               expected result into a queue; a monitor pops and compares on
//               every output transfer and checks stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_align;

  typedef logic [102:0] vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        op_sub;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_x, exp_y, exp_diff;
  logic [23:0] mant_x, mant_y;
  logic        sign_x, sign_y, swap, do_sub;
  logic [26:0] aligned_y;

  always #5 clk = ~clk;

  fp_add_align dut (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_a           (a),
    .i_b           (b),
    .i_op_sub      (op_sub),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_exp_x       (exp_x),
    .o_exp_y       (exp_y),
    .o_mantissa_x  (mant_x),
    .o_mantissa_y  (mant_y),
    .o_sign_x      (sign_x),
    .o_sign_y      (sign_y),
    .o_swap        (swap),
    .o_do_subtract (do_sub),
    .o_exp_diff    (exp_diff),
    .o_aligned_y   (aligned_y)
  );

  vec_t act_vec;
  assign act_vec = {exp_x, exp_y, mant_x, mant_y, sign_x, sign_y, swap, do_sub,
                    exp_diff, aligned_y};

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic bp_en    = 1'b0;

  task automatic check(input string name, input vec_t act, input vec_t expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic vec_t pack(input logic [7:0] ex, input logic [7:0] ey,
                                input logic [23:0] mx, input logic [23:0] my,
                                input logic sx, input logic sy, input logic sw,
                                input logic ds, input logic [7:0] d,
                                input logic [26:0] al);
    return {ex, ey, mx, my, sx, sy, sw, ds, d, al};
  endfunction

  // Reference model: plain integer arithmetic on the binary32 fields.
  function automatic vec_t model(input logic [31:0] ra, input logic [31:0] rb,
                                 input logic op);
    longint ma, mb, mx, my, v, q, rem, p;
    int     ex, ey, effx, effy, d;
    logic   sw;
    logic [31:0] x, y;
    ma = longint'(ra[30:0]);
    mb = longint'(rb[30:0]);
    sw = (mb > ma);
    x  = sw ? rb : ra;
    y  = sw ? ra : rb;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'(x[22:0]) + ((ex != 0) ? 64'd8388608 : 64'd0);
    my = longint'(y[22:0]) + ((ey != 0) ? 64'd8388608 : 64'd0);
    effx = (ex == 0) ? 1 : ex;
    effy = (ey == 0) ? 1 : ey;
    d  = effx - effy;
    v  = my * 8;
    if (d >= 27) begin
      q = (v != 0) ? 1 : 0;
    end else begin
      p   = longint'(1) << d;
      q   = v / p;
      rem = v % p;
      if (rem != 0) q = q | 1;
    end
    return pack(8'(ex), 8'(ey), 24'(mx), 24'(my), x[31], y[31], sw,
                op ^ ra[31] ^ rb[31], 8'(d), 27'(q));
  endfunction

  // Offer one operand pair; expected result is queued at the accepting edge.
  task automatic send(input logic [31:0] ra, input logic [31:0] rb,
                      input logic op, input vec_t expv);
    int cnt;
    bit ok;
    in_valid = 1'b1;
    a = ra; b = rb; op_sub = op;
    ok = 0;
    for (cnt = 0; cnt < 200; cnt++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      check("send_timeout", 103'd0, 103'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_fp(input logic [7:0] base);
    logic [7:0]  e;
    logic [22:0] f;
    int r;
    r = int'($urandom % 8);
    case (r)
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3, 4: e = base + 8'($urandom % 5) - 8'd2;
      default: e = 8'($urandom);
    endcase
    f = ($urandom % 4 == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  // Monitor: compare on each output transfer; check stability across stalls.
  bit   hold_prev = 0;
  vec_t prev_vec;
  always @(negedge clk) begin
    if (rst) begin
      hold_prev <= 0;
    end else begin
      if (hold_prev && out_valid) check("stall_stable", act_vec, prev_vec);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", act_vec, 103'd0 - 103'd1);
        else check("result", act_vec, exp_q.pop_front());
      end
      hold_prev <= out_valid && !out_ready;
      prev_vec  <= act_vec;
    end
  end

  // Random backpressure generator, active only when enabled.
  always @(posedge clk) begin
    if (bp_en) begin
      #1;
      if (bp_en) out_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic        op;
    int          k;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 103'(out_valid), 103'd0);
    check("rst_data", act_vec, 103'd0);
    @(posedge clk); #2 rst = 1'b0; #1;
    check("rst_in_ready", 103'(in_ready), 103'd1);
    @(posedge clk); #1;

    // Directed cases with hand-derived expectations
    send(32'h3F800000, 32'h40000000, 1'b0,
         pack(8'h80, 8'h7F, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 27'h2000000));
    send(32'h3F800000, 32'hBF800000, 1'b0,
         pack(8'h7F, 8'h7F, 24'h800000, 24'h800000, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 27'h4000000));
    send(32'h4B800000, 32'h3F800001, 1'b0,
         pack(8'h97, 8'h7F, 24'h800000, 24'h800001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd24, 27'h0000005));
    send(32'h7F000000, 32'h00000001, 1'b0,
         pack(8'hFE, 8'h00, 24'h800000, 24'h000001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd253, 27'h0000001));
    repeat (4) @(posedge clk);
    #1;

    // Five back-to-back with a 4-cycle stall
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          ra = rand_fp(8'h80);
          rb = rand_fp(8'h80);
          op = 1'($urandom);
          send(ra, rb, op, model(ra, rb, op));
        end
      end
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 103'(in_ready), 103'd0);
        check("stall_out_valid", 103'(out_valid), 103'd1);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    check("stall_drained", 103'(exp_q.size()), 103'd0);

    // Randomized stream with random backpressure, including ties
    bp_en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      ra = rand_fp(8'($urandom));
      rb = rand_fp(ra[30:23]);
      if ($urandom % 10 == 0) rb = {~ra[31], ra[30:0]};
      op = 1'($urandom);
      send(ra, rb, op, model(ra, rb, op));
    end
    bp_en = 1'b0;
    #1 out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("random_drained", 103'(exp_q.size()), 103'd0);
    repeat (3) @(negedge clk);
    check("no_extra_output", 103'(out_valid), 103'd0);

    // Reset with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h40400000, 32'h3F000000, 1'b1, model(32'h40400000, 32'h3F000000, 1'b1));
    send(32'hC1200000, 32'h41200000, 1'b0, model(32'hC1200000, 32'h41200000, 1'b0));
    @(negedge clk);
    check("full_in_ready", 103'(in_ready), 103'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 103'(out_valid), 103'd0);
    check("midrst_data", act_vec, 103'd0);
    exp_q.delete();
    @(posedge clk); #2 rst = 1'b0; #1;
    check("postrst_in_ready", 103'(in_ready), 103'd1);
    out_ready = 1'b1;
    send(32'h3F800000, 32'h40000000, 1'b0,
         pack(8'h80, 8'h7F, 24'h800000, 24'h800000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 27'h2000000));
    @(negedge clk);
    check("latency_1", 103'(out_valid), 103'd0);
    @(negedge clk);
    check("latency_2", 103'(out_valid), 103'd1);
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 103'(exp_q.size()), 103'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_add_align.md
# fp_add_align

Operand-unpack and alignment stage of the single-precision FP adder/subtractor, directly upstream of the special-case detector and the mantissa adder. It accepts two raw IEEE-754 binary32 operands plus an add/subtract opcode. It orders them by magnitude and produces the fields the special-case detector consumes: exponents, hidden-bit mantissas, signs, `swap` and `do_subtract`. It also produces the smaller mantissa right-aligned with guard/round/sticky bits. The block is a 2-stage valid/ready pipeline.

## Interface
- No parameters; widths come from the shared package.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  stage can accept
- `a`, `b`  in  32  raw binary32 operands
- `op_sub`  in  1  1 = a − b, 0 = a + b
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts
- `exp_x`, `exp_y`  out  8  raw exponent fields of larger/smaller operand
- `mantissa_x`, `mantissa_y`  out  24  {hidden, frac}; hidden = (exp != 0)
- `sign_x`, `sign_y`  out  1  raw signs of larger/smaller operand
- `swap`  out  1  1 when b was routed to x
- `do_subtract`  out  1  effective subtraction = op_sub ^ a[31] ^ b[31]
- `exp_diff`  out  8  effective-exponent difference, x − y
- `aligned_y`  out  27  {mantissa_y, 3'b000} >> exp_diff, sticky ORed into bit 0

## Operation
- Magnitude compare on `{exp, frac}` (31 bits, sign ignored).
  - `swap = (b[30:0] > a[30:0])`.
  - On a tie, `swap = 0` and a is x.
- Effective exponent is `exp` when nonzero and 1 for denormals/zero. `exp_diff = eff_x − eff_y` lies in 0..254, and 255 never occurs for finite pairs. Inf/NaN operands are still processed arithmetically. Their outputs are don't-care for `aligned_y` but must be deterministic.
- Alignment shifts right by `exp_diff`.
  - For shift ≥ 27, the shifted value is 0.
  - Sticky = OR of all bits shifted out, and is ORed into bit 0.
- Stage 1 registers the unpacked/ordered fields and `exp_diff`. Stage 2 registers the shifter result and forwards the stage-1 fields.
- Handshake:
  - A transfer occurs when `valid && ready` on a rising edge.
  - Stage 2 loads when `!s2_valid || out_ready`.
  - `in_ready = !s1_valid || s2_load`, so the pipeline has full throughput with no bubbles under continuous `out_ready`.
  - Outputs are stable while `out_valid && !out_ready`.
  - There is no combinational path from `in_valid` or `a`/`b` to any output.
  - `in_ready` depends only on state and `out_ready`.

## Timing
- Latency: 2 cycles, measured from the input transfer edge to `out_valid` high on the second following edge. Throughput is 1 per cycle.
- Reset is asynchronous. On `rst`:
  - Both stage valids clear immediately and `out_valid = 0`.
  - All data outputs = 0.
  - `in_ready` = 1 once `rst` is low.
- Reset mid-operation discards in-flight data. No partial result is ever presented.
- Stall with both stages full holds both stages, and `in_ready = 0` in that cycle.
- Simultaneous output transfer and input transfer in the same cycle: both stages advance, and nothing is lost or duplicated.

## Structure
- The shared package `fp_add_pkg` holds:
  - `EXP_W=8`, `FRAC_W=23`, `MANT_W=24`, `GRS_W=3`, `EXP_SPECIAL=8'hFF`
  - a packed `fp_unpacked_t {sign, exp, mant}` typedef, reused by the special-case detector and downstream stages.
- Sub-module `fp_align_shifter` is combinational: 27-bit right shift by 8-bit amount, with sticky collapse.

## Test plan
- a=0x3F800000, b=0x40000000, op_sub=0 -> after 2 cycles: swap=1, exp_x=0x80, exp_y=0x7F, mantissa_x=0x800000, exp_diff=1, aligned_y=0x2000000, do_subtract=0.
- a=0x3F800000, b=0xBF800000, op_sub=0 -> swap=0, do_subtract=1, exp_diff=0, aligned_y=0x4000000, sign_x=0, sign_y=1.
- a=0x4B800000, b=0x3F800001 -> exp_diff=24, mantissa_y=0x800001, aligned_y=0x0000005 (sticky set).
- a=0x7F000000, b=0x00000001 (denormal) -> mantissa_y=0x000001, exp_diff=253, aligned_y=0x0000001.
- 5 back-to-back inputs with out_ready=0 for 4 cycles then 1 -> in_ready drops after 2 accepted; all 5 results emerge in order, none lost or duplicated, and outputs are stable during the stall.
- rst pulsed (mid-cycle) with both stages full -> out_valid falls immediately, all data outputs = 0, and after release the first new input appears 2 cycles later.
